// File: rtl/lc3b_mem_responder_pkg.sv
// Shared types for the LC-3b memory responder.
// Word, write mask and responder FSM state.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } lc3b_memresp_state_t;

endpackage

// File: rtl/lc3b_mem_responder_mem_array.sv
// Word store with byte-masked synchronous write
// and registered synchronous read; contents survive reset.
module mem_array
  import lc3b_types::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  lc3b_mem_wmask i_be,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  lc3b_word      i_wdata,
  output lc3b_word      o_rdata
);

  lc3b_word r_mem [DEPTH];
  lc3b_word r_q;

  always_ff @(posedge clk) begin
    if (i_we && i_be[0]) begin
      r_mem[i_addr][7:0] <= i_wdata[7:0];
    end
    if (i_we && i_be[1]) begin
      r_mem[i_addr][15:8] <= i_wdata[15:8];
    end
    if (i_re) begin
      r_q <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/lc3b_mem_responder.sv
// LC-3b memory-side responder: fixed-latency read/write
// service of level-held requests with a sticky protocol flag.
module lc3b_mem_responder
  import lc3b_types::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          mem_read,
  input  logic          mem_write,
  input  lc3b_mem_wmask mem_byte_enable,
  input  logic [15:0]   mem_address,
  input  lc3b_word      mem_wdata,
  output logic          mem_resp,
  output lc3b_word      mem_rdata,
  output logic          proto_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (LATENCY < 1 || LATENCY > 15) begin : g_lat_chk
    $error("lc3b_mem_responder: LATENCY must be 1..15");
  end
  if (DEPTH < 1 || DEPTH > 32768) begin : g_depth_chk
    $error("lc3b_mem_responder: DEPTH must be 1..32768");
  end

  lc3b_memresp_state_t r_state;
  lc3b_memresp_state_t w_next;

  logic          r_rd;
  logic          r_wr;
  logic [15:0]   r_addr;
  lc3b_mem_wmask r_be;
  lc3b_word      r_wdata;
  logic [3:0]    r_count;
  logic          r_err;
  logic          r_rzero;

  logic          w_req;
  logic          w_idle;
  logic          w_is_wr;
  logic [15:0]   w_addr;
  lc3b_mem_wmask w_be;
  lc3b_word      w_wdata;
  logic [14:0]   w_idx;
  logic          w_inrange;
  logic          w_mismatch;
  logic          w_err_set;
  logic          w_go;
  logic          w_we;
  logic          w_re;
  lc3b_word      w_q;

  assign w_req  = mem_read | mem_write;
  assign w_idle = (r_state == IDLE);

  // With LATENCY==1 the commit edge is the accept edge,
  // so the live request stands in for the latches.
  assign w_is_wr = w_idle ? mem_write : r_wr;
  assign w_addr  = w_idle ? mem_address : r_addr;
  assign w_be    = w_idle ? mem_byte_enable : r_be;
  assign w_wdata = w_idle ? mem_wdata : r_wdata;

  assign w_idx     = w_addr[15:1];
  assign w_inrange = {1'b0, w_idx} < 16'(DEPTH);

  assign w_mismatch = (mem_read != r_rd)
                    | (mem_write != r_wr)
                    | (mem_address != r_addr)
                    | (mem_wdata != r_wdata)
                    | (mem_byte_enable != r_be);

  always_comb begin
    w_next    = r_state;
    w_err_set = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_req) begin
          w_next    = (LATENCY == 1) ? RESP : WAIT;
          w_err_set = mem_read & mem_write;
        end
      end
      WAIT: begin
        if (!w_req) begin
          w_next    = IDLE;
          w_err_set = 1'b1;
        end else begin
          w_err_set = w_mismatch;
          if (r_count == 4'd1) begin
            w_next = RESP;
          end
        end
      end
      RESP: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  assign w_go = (w_next == RESP);
  assign w_we = w_go & w_is_wr & w_inrange & reset_n;
  assign w_re = w_go & ~w_is_wr & w_inrange;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
      r_rzero <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_err_set) begin
        r_err <= 1'b1;
      end
      if (w_idle && w_req) begin
        r_rd    <= mem_read;
        r_wr    <= mem_write;
        r_addr  <= mem_address;
        r_be    <= mem_byte_enable;
        r_wdata <= mem_wdata;
        r_count <= 4'(LATENCY - 1);
      end else if (r_state == WAIT) begin
        r_count <= r_count - 4'd1;
      end
      if (w_go && !w_is_wr) begin
        r_rzero <= ~w_inrange;
      end
    end
  end

  mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_be    (w_be),
    .i_re    (w_re),
    .i_addr  (w_idx[AW-1:0]),
    .i_wdata (w_wdata),
    .o_rdata (w_q)
  );

  assign mem_resp  = (r_state == RESP);
  assign mem_rdata = r_rzero ? 16'h0000 : w_q;
  assign proto_err = r_err;

endmodule
